// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one vector per accepted start, one micro-rotation
// per clock, with a quadrant fold ahead of the iterations so rotation covers
// the full +/-180 degree range and vectoring accepts left-half-plane inputs.
// The gain K (~1.6468) is not compensated.
//
// Handshake: start_i is a request that is taken only while busy_o is low
// (IDLE or DONE). There is no back-pressure. A start that arrives while
// busy_o is high is ignored. Every accepted job produces exactly one
// single-cycle valid_o pulse, and x_o/y_o/phi_o stay stable until the next
// job completes. When a start is accepted in the first DONE cycle, valid_o
// for the finishing job still pulses in the next cycle while the new job is
// already in PRE.
module cordic_iter_engine #(
  parameter int WIDTH    = 16,
  parameter int ANGLE_W  = 16,
  parameter int MAX_ITER = 12,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      mode_i,
  input  logic [ITER_W-1:0]         num_iter_i,
  input  logic signed [WIDTH-1:0]   x_i,
  input  logic signed [WIDTH-1:0]   y_i,
  input  logic signed [ANGLE_W-1:0] phi_i,
  output logic                      busy_o,
  output logic                      valid_o,
  output logic signed [WIDTH+1:0]   x_o,
  output logic signed [WIDTH+1:0]   y_o,
  output logic signed [ANGLE_W-1:0] phi_o,
  output logic [ITER_W-1:0]         iter_o,
  output logic [1:0]                state_o
);

  localparam int XW = WIDTH + 2;
  localparam int AW = ANGLE_W;

  // The atan table is stored in 16-bit binary angle units. Narrower angles
  // drop the low bits with round-half-up.
  localparam int          SH      = 16 - ANGLE_W;
  localparam logic [16:0] RND_ADD = 17'((1 << SH) >> 1);

  localparam logic [ITER_W-1:0] MAX_N = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic                  mode_q;
  logic                  first_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [ITER_W-1:0]     n_q;
  logic [ITER_W-1:0]     iter_q;
  logic signed [XW-1:0]  x_q, y_q;
  logic signed [AW-1:0]  z_q;
  logic signed [XW-1:0]  x_d, y_d;
  logic signed [AW-1:0]  z_d;
  logic signed [XW-1:0]  x_out_q, y_out_q;
  logic signed [AW-1:0]  z_out_q;

  logic [ITER_W-1:0]     n_clamp;
  logic signed [XW-1:0]  x_pre, y_pre;
  logic signed [AW-1:0]  z_pre;
  logic signed [XW-1:0]  x_sh, y_sh;
  logic signed [XW-1:0]  x_step, y_step;
  logic signed [AW-1:0]  z_step;
  logic signed [AW-1:0]  atan_cur;
  logic                  dir_pos;
  logic                  accept;
  logic                  last_iter;

  // atan(2^-i) in binary angle units, scaled to ANGLE_W bits.
  function automatic logic signed [AW-1:0] atan_f(input logic [4:0] idx);
    logic [16:0] base;
    case (idx)
      5'd0:    base = 17'd8192;
      5'd1:    base = 17'd4836;
      5'd2:    base = 17'd2555;
      5'd3:    base = 17'd1297;
      5'd4:    base = 17'd651;
      5'd5:    base = 17'd326;
      5'd6:    base = 17'd163;
      5'd7:    base = 17'd81;
      5'd8:    base = 17'd41;
      5'd9:    base = 17'd20;
      5'd10:   base = 17'd10;
      5'd11:   base = 17'd5;
      5'd12:   base = 17'd3;
      5'd13:   base = 17'd1;
      5'd14:   base = 17'd1;
      default: base = 17'd0;
    endcase
    base = (base + RND_ADD) >> SH;
    return AW'(base);
  endfunction

  assign accept    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter = (iter_q == (n_q - ITER_W'(1)));

  // Clamp the requested iteration count into 1..MAX_ITER.
  always_comb begin
    n_clamp = num_iter_i;
    if (num_iter_i == '0) begin
      n_clamp = ITER_W'(1);
    end else if (num_iter_i > MAX_N) begin
      n_clamp = MAX_N;
    end
  end

  // Quadrant fold: bring the problem into the right half plane (vectoring)
  // or into |z| < 90 degrees (rotation) by a 180 degree turn.
  always_comb begin
    x_pre = x_q;
    y_pre = y_q;
    z_pre = z_q;
    if (!mode_q) begin
      if (z_q[AW-1] ^ z_q[AW-2]) begin
        x_pre = -x_q;
        y_pre = -y_q;
        z_pre = {~z_q[AW-1], z_q[AW-2:0]};
      end
    end else begin
      if (x_q[XW-1]) begin
        x_pre = -x_q;
        y_pre = -y_q;
        z_pre = {1'b1, {(AW-1){1'b0}}};
      end
    end
  end

  // One CORDIC micro-rotation at index iter_q.
  always_comb begin
    atan_cur = atan_f(5'(iter_q));
    x_sh     = x_q >>> iter_q;
    y_sh     = y_q >>> iter_q;
    dir_pos  = mode_q ? y_q[XW-1] : ~z_q[AW-1];
    if (dir_pos) begin
      x_step = x_q - y_sh;
      y_step = y_q + x_sh;
      z_step = z_q - atan_cur;
    end else begin
      x_step = x_q + y_sh;
      y_step = y_q - x_sh;
      z_step = z_q + atan_cur;
    end
  end

  // Select the next datapath value: load on accept, fold in PRE, step in ITER.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          x_d = {{2{x_i[WIDTH-1]}}, x_i};
          y_d = {{2{y_i[WIDTH-1]}}, y_i};
          z_d = mode_i ? '0 : phi_i;
        end
      end
      S_PRE: begin
        x_d = x_pre;
        y_d = y_pre;
        z_d = z_pre;
      end
      S_ITER: begin
        x_d = x_step;
        y_d = y_step;
        z_d = z_step;
      end
      default: begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
      end
    endcase
  end

  // Working x/y/z registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  // Control FSM with registered busy/valid/iteration index and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      n_q     <= '0;
      iter_q  <= '0;
      first_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      valid_q <= 1'b0;
      // Results are captured on the first DONE cycle, even if a new job is
      // accepted at the same edge.
      if ((state_q == S_DONE) && first_q) begin
        x_out_q <= x_q;
        y_out_q <= y_q;
        z_out_q <= z_q;
        valid_q <= 1'b1;
        first_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q <= S_PRE;
            mode_q  <= mode_i;
            n_q     <= n_clamp;
            iter_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_PRE: begin
          state_q <= S_ITER;
          iter_q  <= '0;
        end
        S_ITER: begin
          if (last_iter) begin
            state_q <= S_DONE;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            first_q <= 1'b1;
          end else begin
            iter_q <= iter_q + ITER_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign x_o     = x_out_q;
  assign y_o     = y_out_q;
  assign phi_o   = z_out_q;
  assign iter_o  = iter_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: a bit-exact CORDIC reference
// model fills an expected queue when a job is driven; a monitor pops and
// compares results, latency and iteration counts when valid_o pulses.
module tb_cordic_iter_engine;

  localparam int W      = 16;
  localparam int AW     = 16;
  localparam int XW     = W + 2;
  localparam int MAXI   = 12;
  localparam int IW     = 4;
  localparam int EW     = XW + XW + AW;

  logic                 clk;
  logic                 rst;
  logic                 start_i;
  logic                 mode_i;
  logic [IW-1:0]        num_iter_i;
  logic signed [W-1:0]  x_i, y_i;
  logic signed [AW-1:0] phi_i;
  logic                 busy_o, valid_o;
  logic signed [XW-1:0] x_o, y_o;
  logic signed [AW-1:0] phi_o;
  logic [IW-1:0]        iter_o;
  logic [1:0]           state_o;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            lat_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_x, last_y, last_phi;

  int atan_tab[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                       41, 20, 10, 5, 3, 1, 1, 0};

  cordic_iter_engine #(
    .WIDTH(W), .ANGLE_W(AW), .MAX_ITER(MAXI), .ITER_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .num_iter_i(num_iter_i), .x_i(x_i), .y_i(y_i), .phi_i(phi_i),
    .busy_o(busy_o), .valid_o(valid_o), .x_o(x_o), .y_o(y_o),
    .phi_o(phi_o), .iter_o(iter_o), .state_o(state_o)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > MAXI) return MAXI;
    return n;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference CORDIC: fold, then n micro-rotations in XW-bit arithmetic.
  function automatic logic [EW-1:0] model(input logic mode, input int n,
                                          input int xin, input int yin, input int pin);
    logic signed [W-1:0]  xs, ys;
    logic signed [XW-1:0] x, y, xt;
    logic signed [AW-1:0] z, a;
    logic                 d;
    xs = W'(xin);
    ys = W'(yin);
    x  = {{2{xs[W-1]}}, xs};
    y  = {{2{ys[W-1]}}, ys};
    z  = mode ? '0 : AW'(pin);
    if (!mode && (z[AW-1] != z[AW-2])) begin
      x = -x; y = -y; z = z + AW'(32768);
    end else if (mode && x < 0) begin
      x = -x; y = -y; z = AW'(-32768);
    end
    for (int i = 0; i < eff_n(n); i++) begin
      d  = mode ? (y < 0) : (z >= 0);
      xt = x;
      a  = AW'(atan_tab[i]);
      if (d) begin
        x = x - (y >>> i); y = y + (xt >>> i); z = z - a;
      end else begin
        x = x + (y >>> i); y = y - (xt >>> i); z = z + a;
      end
    end
    return {x, y, z};
  endfunction

  // Driver: present one job for a single cycle at a negedge; the DUT is
  // expected to accept it at the next posedge.
  task automatic drive_job(input logic mode, input int n, input int x, input int y, input int phi);
    start_i    = 1'b1;
    mode_i     = mode;
    num_iter_i = IW'(n);
    x_i        = W'(x);
    y_i        = W'(y);
    phi_i      = AW'(phi);
    exp_q.push_back(model(mode, n, x, y, phi));
    acc_q.push_back(cyc + 1);
    lat_q.push_back(eff_n(n) + 2);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    int            acc, lat;
    forever begin
      @(negedge clk);
      if (!rst && valid_o) begin
        valid_cnt++;
        last_x   = int'(x_o);
        last_y   = int'(y_o);
        last_phi = int'(phi_o);
        if (exp_q.size() == 0) begin
          check("spurious_valid", valid_o, 1'b0);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          lat = lat_q.pop_front();
          check("x_o",     $unsigned(x_o),   e[EW-1 -: XW]);
          check("y_o",     $unsigned(y_o),   e[EW-XW-1 -: XW]);
          check("phi_o",   $unsigned(phi_o), e[AW-1:0]);
          check("latency", cyc - acc, lat);
        end
      end
    end
  end

  // Main stimulus
  initial begin
    int v0;
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; num_iter_i = '0;
    x_i = '0; y_i = '0; phi_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_x",     $unsigned(x_o), 0);
    check("rst_y",     $unsigned(y_o), 0);
    check("rst_phi",   $unsigned(phi_o), 0);
    check("rst_iter",  iter_o, 0);
    check("rst_state", state_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // Rotation by 45 degrees
    drive_job(1'b0, 12, 10000, 0, 8192);
    check("busy_after_accept", busy_o, 1'b1);
    wait_drain();
    check("rot45_x_near",   iabs(last_x - 11645) <= 8, 1'b1);
    check("rot45_y_near",   iabs(last_y - 11645) <= 8, 1'b1);
    check("rot45_phi_near", iabs(last_phi) <= 4, 1'b1);
    check("done_busy_low",  busy_o, 1'b0);
    check("done_state",     state_o, 3);

    // Vectoring at 45 degrees
    drive_job(1'b1, 12, 10000, 10000, 0);
    wait_drain();
    check("vec45_x_near",   iabs(last_x - 23290) <= 8, 1'b1);
    check("vec45_y_near",   iabs(last_y) <= 8, 1'b1);
    check("vec45_phi_near", iabs(last_phi - 8192) <= 4, 1'b1);

    // Pre-rotation cases
    drive_job(1'b0, 12, 10000, 0, -24576);
    wait_drain();
    check("rotm135_x_near", iabs(last_x + 11645) <= 8, 1'b1);
    check("rotm135_y_near", iabs(last_y + 11645) <= 8, 1'b1);
    drive_job(1'b1, 12, -10000, 0, 0);
    wait_drain();
    check("vec180_x_near",   iabs(last_x - 16468) <= 8, 1'b1);
    check("vec180_phi_near", iabs(last_phi) >= 32760, 1'b1);

    // Iteration-count clamping (latency checked by the monitor)
    drive_job(1'b0, 0, 12345, -2222, 3000);
    wait_drain();
    drive_job(1'b1, 15, 7000, -9000, 0);
    wait_drain();

    // Most-negative inputs in both modes
    drive_job(1'b0, 12, -32768, -32768, 20000);
    wait_drain();
    drive_job(1'b1, 12, -32768, -32768, 0);
    wait_drain();

    // Start while busy is ignored
    v0 = valid_cnt;
    drive_job(1'b0, 12, 5000, 4000, -7000);
    repeat (3) @(negedge clk);
    check("busy_mid_job", busy_o, 1'b1);
    start_i = 1'b1; mode_i = 1'b1; x_i = W'(-123); y_i = W'(456);
    @(negedge clk);
    start_i = 1'b0;
    wait_drain();
    repeat (20) @(negedge clk);
    check("busy_start_ignored", valid_cnt - v0, 1);

    // Start held high: back-to-back jobs every N+2 cycles
    v0 = valid_cnt;
    start_i = 1'b1; mode_i = 1'b0; num_iter_i = IW'(4);
    x_i = W'(9000); y_i = W'(-3000); phi_i = AW'(11111);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(model(1'b0, 4, 9000, -3000, 11111));
      acc_q.push_back(cyc + 1 + k * 6);
      lat_q.push_back(6);
    end
    repeat (2 * 6 + 1) @(negedge clk);
    start_i = 1'b0;
    wait_drain();
    check("b2b_valid_count", valid_cnt - v0, 3);

    // Reset in the middle of an iteration
    drive_job(1'b0, 12, 10000, 0, 8192);
    for (int k = 0; k < 40 && iter_o != IW'(5); k++) @(negedge clk);
    check("saw_iter5", iter_o, 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy",  busy_o, 1'b0);
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_x",     $unsigned(x_o), 0);
    check("midrst_y",     $unsigned(y_o), 0);
    check("midrst_phi",   $unsigned(phi_o), 0);
    check("midrst_iter",  iter_o, 0);
    check("midrst_state", state_o, 0);
    rst = 1'b0;
    exp_q.delete(); acc_q.delete(); lat_q.delete();
    v0 = valid_cnt;
    repeat (20) @(negedge clk);
    check("midrst_no_valid", valid_cnt - v0, 0);
    drive_job(1'b1, 10, 3000, -8000, 0);
    wait_drain();

    // Random jobs against the reference model
    for (int k = 0; k < 8; k++) begin
      drive_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768);
      wait_drain();
    end

    check("final_pending", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
